// File: rtl/occupancy_gate_controller.sv
// Door crossing decoder: synchronises and debounces two light beams, tracks walk
// direction and pulses the occupancy counter on completed entries and exits.
module occupancy_gate_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             beam_outer,
  input  logic             beam_inner,
  input  logic [CNT_W-1:0] count,
  input  logic [CNT_W-1:0] max_value,
  output logic             inc_enable,
  output logic             dec_enable,
  output logic             door_lock,
  output logic             seq_err,
  output logic             cap_err,
  output logic             busy,
  output logic [2:0]       state_dbg
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IN_O   = 3'd1,
    IN_OI  = 3'd2,
    IN_I   = 3'd3,
    OUT_I  = 3'd4,
    OUT_IO = 3'd5,
    OUT_O  = 3'd6,
    ERR    = 3'd7
  } state_t;

  logic [1:0] beam_raw;
  logic [1:0] pair;  // filtered {outer, inner}

  assign beam_raw = {beam_outer, beam_inner};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_beam
      logic            sync1_q, sync2_q;
      logic            filt_q, filt_d;
      logic [DB_W-1:0] cnt_q, cnt_d;

      always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
          if (cnt_q == DB_LAST) begin
            filt_d = sync2_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
          filt_q  <= 1'b0;
          cnt_q   <= '0;
        end else begin
          sync1_q <= beam_raw[gi];
          sync2_q <= sync1_q;
          filt_q  <= filt_d;
          cnt_q   <= cnt_d;
        end
      end

      assign pair[gi] = filt_q;
    end
  endgenerate

  state_t          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            inc_q, inc_d;
  logic            dec_q, dec_d;
  logic            seq_q, seq_d;
  logic            cap_q, cap_d;
  logic            lock_q, lock_d;
  logic            entry_done, exit_done;

  always_comb begin
    state_d    = state_q;
    entry_done = 1'b0;
    exit_done  = 1'b0;
    case (state_q)
      IDLE: begin
        case (pair)
          2'b10:   state_d = IN_O;
          2'b01:   state_d = OUT_I;
          2'b11:   state_d = ERR;
          default: state_d = IDLE;
        endcase
      end
      IN_O: begin
        case (pair)
          2'b11:   state_d = IN_OI;
          2'b00:   state_d = IDLE;
          2'b01:   state_d = ERR;
          default: state_d = IN_O;
        endcase
      end
      IN_OI: begin
        case (pair)
          2'b01:   state_d = IN_I;
          2'b10:   state_d = IN_O;
          2'b00:   state_d = ERR;
          default: state_d = IN_OI;
        endcase
      end
      IN_I: begin
        case (pair)
          2'b00: begin
            state_d    = IDLE;
            entry_done = 1'b1;
          end
          2'b11:   state_d = IN_OI;
          2'b10:   state_d = ERR;
          default: state_d = IN_I;
        endcase
      end
      OUT_I: begin
        case (pair)
          2'b11:   state_d = OUT_IO;
          2'b00:   state_d = IDLE;
          2'b10:   state_d = ERR;
          default: state_d = OUT_I;
        endcase
      end
      OUT_IO: begin
        case (pair)
          2'b10:   state_d = OUT_O;
          2'b01:   state_d = OUT_I;
          2'b00:   state_d = ERR;
          default: state_d = OUT_IO;
        endcase
      end
      OUT_O: begin
        case (pair)
          2'b00: begin
            state_d   = IDLE;
            exit_done = 1'b1;
          end
          2'b11:   state_d = OUT_IO;
          2'b01:   state_d = ERR;
          default: state_d = OUT_O;
        endcase
      end
      ERR: begin
        if (pair == 2'b00) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A stalled crossing overrides whatever the beams would have done this cycle.
    if (state_q != IDLE && state_q != ERR && to_cnt_q == TO_LAST) begin
      state_d    = ERR;
      entry_done = 1'b0;
      exit_done  = 1'b0;
    end

    inc_d    = entry_done && (count < max_value);
    dec_d    = exit_done && (count != '0);
    cap_d    = (entry_done && !(count < max_value)) || (exit_done && (count == '0));
    seq_d    = (state_d == ERR) && (state_q != ERR);
    to_cnt_d = (state_q == IDLE || state_d != state_q) ? '0 : to_cnt_q + 1'b1;
    lock_d   = (count >= max_value);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      to_cnt_q <= '0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      seq_q    <= 1'b0;
      cap_q    <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      seq_q    <= seq_d;
      cap_q    <= cap_d;
      lock_q   <= lock_d;
    end
  end

  assign inc_enable = inc_q;
  assign dec_enable = dec_q;
  assign seq_err    = seq_q;
  assign cap_err    = cap_q;
  assign door_lock  = lock_q;
  assign busy       = (state_q != IDLE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_occupancy_gate_controller.sv
// Directed bench for occupancy_gate_controller: beam sequences with hand-computed
// state, pulse-count and door-lock expectations.
module tb_occupancy_gate_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       beam_outer;
  logic       beam_inner;
  logic [3:0] count;
  logic [3:0] max_value;
  logic       inc_enable;
  logic       dec_enable;
  logic       door_lock;
  logic       seq_err;
  logic       cap_err;
  logic       busy;
  logic [2:0] state_dbg;

  int n_vec = 0;
  int n_bad = 0;

  int n_inc = 0, n_dec = 0, n_seq = 0, n_cap = 0, n_busy = 0, n_both = 0;
  int b_inc, b_dec, b_seq, b_cap, b_busy;

  occupancy_gate_controller #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (16),
    .CNT_W          (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .beam_outer(beam_outer),
    .beam_inner(beam_inner),
    .count     (count),
    .max_value (max_value),
    .inc_enable(inc_enable),
    .dec_enable(dec_enable),
    .door_lock (door_lock),
    .seq_err   (seq_err),
    .cap_err   (cap_err),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // Tally cycles each pulse output is high, sampled mid-cycle.
  always @(negedge clk) begin
    if (inc_enable === 1'b1) n_inc <= n_inc + 1;
    if (dec_enable === 1'b1) n_dec <= n_dec + 1;
    if (seq_err === 1'b1) n_seq <= n_seq + 1;
    if (cap_err === 1'b1) n_cap <= n_cap + 1;
    if (busy === 1'b1) n_busy <= n_busy + 1;
    if (inc_enable === 1'b1 && dec_enable === 1'b1) n_both <= n_both + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_inc  = n_inc;
    b_dec  = n_dec;
    b_seq  = n_seq;
    b_cap  = n_cap;
    b_busy = n_busy;
  endtask

  task automatic phase(input logic o, input logic i);
    beam_outer = o;
    beam_inner = i;
    tick(10);
    $display("phase beams=%b%b count=%0d max=%0d -> state=%0d", o, i, count, max_value, state_dbg);
  endtask

  initial begin
    reset      = 1'b0;
    beam_outer = 1'b1;
    beam_inner = 1'b0;
    count      = 4'd0;
    max_value  = 4'd8;
    tick(3);
    chk("rst inc", inc_enable, 0);
    chk("rst dec", dec_enable, 0);
    chk("rst seq", seq_err, 0);
    chk("rst cap", cap_err, 0);
    chk("rst lock", door_lock, 0);
    chk("rst busy", busy, 0);
    chk("rst state", state_dbg, 0);

    reset      = 1'b1;
    beam_outer = 1'b0;
    tick(10);
    chk("post-rst state", state_dbg, 0);
    chk("post-rst lock", door_lock, 0);

    // Entry with room to spare.
    count = 4'd3;
    snap();
    phase(1'b1, 1'b0); chk("entry s1", state_dbg, 1);
    phase(1'b1, 1'b1); chk("entry s2", state_dbg, 2);
    phase(1'b0, 1'b1); chk("entry s3", state_dbg, 3);
    phase(1'b0, 1'b0); chk("entry s0", state_dbg, 0);
    chk("entry inc", n_inc - b_inc, 1);
    chk("entry dec", n_dec - b_dec, 0);
    chk("entry seq", n_seq - b_seq, 0);
    chk("entry cap", n_cap - b_cap, 0);

    // Exit from an empty room.
    count = 4'd0;
    snap();
    phase(1'b0, 1'b1); chk("exit0 s4", state_dbg, 4);
    phase(1'b1, 1'b1); chk("exit0 s5", state_dbg, 5);
    phase(1'b1, 1'b0); chk("exit0 s6", state_dbg, 6);
    phase(1'b0, 1'b0); chk("exit0 s0", state_dbg, 0);
    chk("exit0 dec", n_dec - b_dec, 0);
    chk("exit0 cap", n_cap - b_cap, 1);
    chk("exit0 inc", n_inc - b_inc, 0);

    // Exit with occupants.
    count = 4'd5;
    snap();
    phase(1'b0, 1'b1);
    phase(1'b1, 1'b1);
    phase(1'b1, 1'b0);
    phase(1'b0, 1'b0);
    chk("exit5 dec", n_dec - b_dec, 1);
    chk("exit5 cap", n_cap - b_cap, 0);
    chk("exit5 state", state_dbg, 0);

    // Three-cycle glitch is filtered out entirely.
    snap();
    beam_outer = 1'b1;
    tick(3);
    beam_outer = 1'b0;
    tick(10);
    $display("glitch 3 cycles -> busy cycles=%0d", n_busy - b_busy);
    chk("glitch3 busy", n_busy - b_busy, 0);
    chk("glitch3 state", state_dbg, 0);

    // Four-cycle pulse just passes: IN_O for 4 cycles, then abort.
    snap();
    beam_outer = 1'b1;
    tick(4);
    beam_outer = 1'b0;
    tick(12);
    $display("pulse 4 cycles -> busy cycles=%0d", n_busy - b_busy);
    chk("pulse4 busy", n_busy - b_busy, 4);
    chk("pulse4 pulses", (n_inc - b_inc) + (n_dec - b_dec) + (n_seq - b_seq) + (n_cap - b_cap), 0);

    // Abort an entry.
    snap();
    phase(1'b1, 1'b0); chk("abort s1", state_dbg, 1);
    phase(1'b0, 1'b0); chk("abort s0", state_dbg, 0);
    chk("abort pulses", (n_inc - b_inc) + (n_dec - b_dec) + (n_seq - b_seq) + (n_cap - b_cap), 0);

    // Illegal jump 10 -> 01, ERR held well past the timeout length.
    snap();
    phase(1'b1, 1'b0);
    phase(1'b0, 1'b1); chk("illegal s7", state_dbg, 7);
    chk("illegal seq", n_seq - b_seq, 1);
    phase(1'b0, 1'b1);
    phase(1'b0, 1'b1); chk("err hold s7", state_dbg, 7);
    chk("err hold seq", n_seq - b_seq, 1);
    phase(1'b0, 1'b0); chk("err exit s0", state_dbg, 0);
    chk("illegal other", (n_inc - b_inc) + (n_dec - b_dec) + (n_cap - b_cap), 0);

    // Timeout: IN_O entered 7 edges after the raw change, ERR 16 edges later.
    snap();
    beam_outer = 1'b1;
    tick(22);
    chk("to pre s1", state_dbg, 1);
    chk("to pre seq", n_seq - b_seq, 0);
    tick(1);
    $display("timeout -> state=%0d seq_err=%0b", state_dbg, seq_err);
    chk("to s7", state_dbg, 7);
    chk("to seq_err", seq_err, 1);
    phase(1'b0, 1'b0); chk("to recover s0", state_dbg, 0);
    chk("to seq total", n_seq - b_seq, 1);

    // Full room: lock follows one cycle later, entry reports capacity error.
    count     = 4'd8;
    max_value = 4'd8;
    chk("lock before edge", door_lock, 0);
    tick(1);
    chk("lock full", door_lock, 1);
    snap();
    phase(1'b1, 1'b0);
    phase(1'b1, 1'b1);
    phase(1'b0, 1'b1);
    phase(1'b0, 1'b0);
    chk("full inc", n_inc - b_inc, 0);
    chk("full cap", n_cap - b_cap, 1);

    // Exit from a full room still decrements.
    snap();
    phase(1'b0, 1'b1);
    phase(1'b1, 1'b1);
    phase(1'b1, 1'b0);
    phase(1'b0, 1'b0);
    chk("full exit dec", n_dec - b_dec, 1);
    chk("full exit cap", n_cap - b_cap, 0);

    count     = 4'd7;
    tick(1);
    chk("lock 7of8", door_lock, 0);
    count     = 4'd9;
    tick(1);
    chk("lock 9of8", door_lock, 1);
    count     = 4'd0;
    max_value = 4'd0;
    tick(1);
    chk("lock max0", door_lock, 1);

    chk("inc&dec together", n_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/occupancy_gate_controller.md
Name: occupancy_gate_controller

Overview:
- Sequences the room occupancy counter from two door light-beam sensors: outer beam and inner beam.
- Synchronises and debounces both beams, then decodes walk direction with a state machine.
- Issues single-cycle inc_enable/dec_enable pulses to the occupancy counter.
- Drives a door lock when the room is full and flags aborted, illegal or timed-out crossings.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised beam must differ from its filtered value before the filtered value updates (>=1)
TIMEOUT_CYCLES, 1000, max cycles allowed in any non-IDLE state before ERR
CNT_W, 4, width of count/max_value

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous active-low reset; all state cleared on a clk edge where reset==0
beam_outer  input  1  raw asynchronous outer sensor, 1 = beam broken
beam_inner  input  1  raw asynchronous inner sensor, 1 = beam broken
count  input  CNT_W  current occupancy from the counter
max_value  input  CNT_W  room capacity
inc_enable  output  1  one-cycle pulse: one person entered
dec_enable  output  1  one-cycle pulse: one person left
door_lock  output  1  registered; 1 when count >= max_value
seq_err  output  1  one-cycle pulse: illegal transition or timeout
cap_err  output  1  one-cycle pulse: entry completed while locked, or exit completed with count==0
busy  output  1  registered; 1 when state != IDLE
state_dbg  output  3  current FSM state encoding

Behaviour:
- Reset (reset==0 at edge): sync flops, filtered beams, debounce and timeout counters = 0; state = IDLE; all outputs 0.
- Synchroniser: 2 flops per beam.
- Debounce, per beam:
  - If synced == filtered, counter <= 0.
  - Else counter increments; on the edge where counter == DEBOUNCE_CYCLES-1, filtered <= synced and counter <= 0.
  - Raw edge to filtered edge = 2 + DEBOUNCE_CYCLES cycles.
- Decoding uses filtered pair {o,i}.
- States: IDLE=0, IN_O=1, IN_OI=2, IN_I=3, OUT_I=4, OUT_IO=5, OUT_O=6, ERR=7.
- Transitions (pair not listed = stay, except unlisted changes -> ERR):
  - IDLE: 10->IN_O; 01->OUT_I; 11->ERR.
  - IN_O: 11->IN_OI; 00->IDLE (abort, no pulse); 01->ERR.
  - IN_OI: 01->IN_I; 10->IN_O (back-out); 00->ERR.
  - IN_I: 00->IDLE with entry completion; 11->IN_OI; 10->ERR.
  - OUT_I: 11->OUT_IO; 00->IDLE (abort); 10->ERR.
  - OUT_IO: 10->OUT_O; 01->OUT_I; 00->ERR.
  - OUT_O: 00->IDLE with exit completion; 11->OUT_IO; 01->ERR.
  - ERR: stay until pair==00, then IDLE. No pulses while in ERR.
- Completions:
  - Entry: inc_enable=1 for exactly one cycle, on the same edge the state enters IDLE, if count < max_value. Otherwise cap_err pulses instead.
  - Exit: dec_enable=1 for one cycle if count != 0. Otherwise cap_err pulses.
  - inc_enable and dec_enable are never both 1.
- seq_err pulses one cycle on the edge the state enters ERR.
- Timeout:
  - Counter clears on every state change and in IDLE; increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1 in a non-IDLE, non-ERR state, next state = ERR and seq_err pulses.
  - ERR itself has no timeout.
- door_lock registered from count/max_value every cycle, one-cycle latency; max_value==0 -> always locked.
- busy and state_dbg reflect the registered state.
- Reset mid-crossing: state -> IDLE, no pulse emitted, filters cleared.

Test Plan:
- Reset held low 3 cycles with beam_outer=1 -> all outputs 0, state_dbg=0; after release with beams 0, state stays IDLE.
- Entry sequence with each filtered phase held 10 cycles (10,11,01,00), count=3, max_value=8 -> exactly one inc_enable pulse, seq_err=0, state_dbg returns to 0.
- Exit sequence (01,11,10,00), count=0 -> no dec_enable, one cap_err pulse; repeat with count=5 -> one dec_enable pulse.
- Glitch of 3 cycles on beam_outer with DEBOUNCE_CYCLES=4 -> filtered stays 0, state IDLE. Abort sequence 10,00 -> IDLE, no pulses.
- Illegal jump 10 then directly 01 -> seq_err pulse, state_dbg=7; hold 01 -> stays ERR; release to 00 -> IDLE.
- Hold 10 for TIMEOUT_CYCLES=16 cycles -> seq_err at cycle 16, ERR. Separately, count=8, max_value=8 -> door_lock=1 within one cycle, and a full entry gives cap_err with no inc_enable.
